// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the camera frame capture controller.
// Optional ROI cropping is enabled by defining CAM_ROI_CROP_EN.
package cam_capture_pkg;

   localparam int CNT_W = 16;
   localparam int ROI_W = 12;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_LOW = 2'd1,
      ST_WAIT_FS  = 2'd2,
      ST_CAPTURE  = 2'd3
   } cap_state_t;

   // Pixel and line counters hold at all-ones instead of wrapping mid-frame.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/cam_sync_edge_det.sv
// Registers VSYNC/HSYNC once and flags edges in the cycle the new level
// is sampled.
module cam_sync_edge_det (
   input  logic CLK,
   input  logic RST,
   input  logic iVSYNC,
   input  logic iHSYNC,
   output logic oVS_RISE,
   output logic oVS_FALL,
   output logic oHS_FALL
);

   logic vsync_q;
   logic hsync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vsync_q <= 1'b0;
         hsync_q <= 1'b0;
      end else begin
         vsync_q <= iVSYNC;
         hsync_q <= iHSYNC;
      end
   end

   assign oVS_RISE = iVSYNC & ~vsync_q;
   assign oVS_FALL = ~iVSYNC & vsync_q;
   assign oHS_FALL = ~iHSYNC & hsync_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Stereo frame capture controller: arms on start, aligns to a full frame,
// writes linear addresses and checks geometry. Macro: CAM_ROI_CROP_EN.
module cam_capture_ctrl
   import cam_capture_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int ADDR_WIDTH  = 19
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     iSTART,
   input  logic                     iABORT,
   input  logic                     iCONTINUOUS,
   input  logic                     iVSYNC,
   input  logic                     iHSYNC,
   input  logic                     iDE,
   input  logic [PIXEL_WIDTH-1:0]   iDATA_L,
   input  logic [PIXEL_WIDTH-1:0]   iDATA_R,
   input  logic                     iWR_READY,
`ifdef CAM_ROI_CROP_EN
   input  logic [ROI_W-1:0]         iROI_X0,
   input  logic [ROI_W-1:0]         iROI_Y0,
   input  logic [ROI_W-1:0]         iROI_W,
   input  logic [ROI_W-1:0]         iROI_H,
`endif
   output logic                     oWR_EN,
   output logic [ADDR_WIDTH-1:0]    oWR_ADDR,
   output logic [2*PIXEL_WIDTH-1:0] oWR_DATA,
   output logic                     oBUSY,
   output logic                     oFRAME_START,
   output logic                     oFRAME_DONE,
   output logic                     oERR_SIZE,
   output logic                     oERR_OVF,
   output logic [15:0]              oFRAME_CNT
);

   localparam logic [31:0] FULL_LIMIT = 32'(H_ACTIVE * V_ACTIVE);

   cap_state_t         state, state_nxt;
   logic               vs_rise, vs_fall, hs_fall;
   logic               arm, frame_start, frame_end;
   logic               pixel, in_roi, cap_pixel, below_limit, wr_ok, line_end;
   logic [31:0]        limit;
   logic [ADDR_WIDTH:0] wr_ptr;
   logic [CNT_W-1:0]   pix_cnt, line_cnt, lines_total;

   cam_sync_edge_det u_edge (
      .CLK      (CLK),
      .RST      (RST),
      .iVSYNC   (iVSYNC),
      .iHSYNC   (iHSYNC),
      .oVS_RISE (vs_rise),
      .oVS_FALL (vs_fall),
      .oHS_FALL (hs_fall)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path
   // leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt   = state;
      arm         = 1'b0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      if (iABORT) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     if (iSTART) begin state_nxt = ST_WAIT_LOW; arm = 1'b1; end
            ST_WAIT_LOW: if (!iVSYNC) state_nxt = ST_WAIT_FS;
            ST_WAIT_FS:  if (vs_rise) begin state_nxt = ST_CAPTURE; frame_start = 1'b1; end
            ST_CAPTURE:  if (vs_fall) begin
                            frame_end = 1'b1;
                            state_nxt = iCONTINUOUS ? ST_WAIT_FS : ST_IDLE;
                         end
            default:     state_nxt = ST_IDLE;
         endcase
      end
   end

`ifdef CAM_ROI_CROP_EN
   assign in_roi = (32'(pix_cnt)  >= 32'(iROI_X0)) && (32'(pix_cnt)  < 32'(iROI_X0) + 32'(iROI_W)) &&
                   (32'(line_cnt) >= 32'(iROI_Y0)) && (32'(line_cnt) < 32'(iROI_Y0) + 32'(iROI_H));
   assign limit  = 32'(iROI_W) * 32'(iROI_H);
`else
   assign in_roi = 1'b1;
   assign limit  = FULL_LIMIT;
`endif

   assign pixel       = iDE & iHSYNC & iVSYNC;
   assign cap_pixel   = (state == ST_CAPTURE) & ~iABORT & pixel & in_roi;
   assign below_limit = 32'(wr_ptr) < limit;
   assign wr_ok       = cap_pixel & iWR_READY & below_limit;
   // A line ending together with VSYNC must still be counted for the frame check.
   assign line_end    = hs_fall & (pix_cnt != '0);
   assign lines_total = line_end ? sat_inc(line_cnt) : line_cnt;
   assign oBUSY       = (state != ST_IDLE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         oWR_EN       <= 1'b0;
         oWR_ADDR     <= '0;
         oWR_DATA     <= '0;
         oFRAME_START <= 1'b0;
         oFRAME_DONE  <= 1'b0;
         oERR_SIZE    <= 1'b0;
         oERR_OVF     <= 1'b0;
         oFRAME_CNT   <= '0;
         wr_ptr       <= '0;
         pix_cnt      <= '0;
         line_cnt     <= '0;
      end else begin
         oWR_EN       <= wr_ok;
         oFRAME_START <= frame_start;
         oFRAME_DONE  <= frame_end;
         if (arm) begin
            oERR_SIZE <= 1'b0;
            oERR_OVF  <= 1'b0;
            oWR_ADDR  <= '0;
            wr_ptr    <= '0;
         end
         if (frame_start) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            oWR_ADDR <= '0;
            wr_ptr   <= '0;
         end
         if (wr_ok) begin
            oWR_ADDR <= wr_ptr[ADDR_WIDTH-1:0];
            oWR_DATA <= {iDATA_R, iDATA_L};
            wr_ptr   <= wr_ptr + 1'b1;
         end
         if (cap_pixel && !iWR_READY) oERR_OVF  <= 1'b1;
         if (cap_pixel && !below_limit) oERR_SIZE <= 1'b1;
         if (state == ST_CAPTURE && !iABORT) begin
            if (pixel) pix_cnt <= sat_inc(pix_cnt);
            if (hs_fall) begin
               pix_cnt <= '0;
               if (line_end) begin
                  line_cnt <= sat_inc(line_cnt);
                  if (pix_cnt != CNT_W'(H_ACTIVE)) oERR_SIZE <= 1'b1;
               end
            end
         end
         if (frame_end) begin
            if (lines_total != CNT_W'(V_ACTIVE)) oERR_SIZE <= 1'b1;
            oFRAME_CNT <= oFRAME_CNT + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl on an 8x4 frame; the ROI case runs
// only when CAM_ROI_CROP_EN is defined.
module tb_cam_capture_ctrl;
   import cam_capture_pkg::*;

   localparam int PW = 8;
   localparam int H  = 8;
   localparam int V  = 4;
   localparam int AW = 5;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [2*PW-1:0] data;
   } wr_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic start = 0, abort = 0, cont = 0, vsync = 0, hsync = 0, de = 0, ready = 1;
   logic [PW-1:0] data_l = '0, data_r = '0;
   logic [ROI_W-1:0] roi_x0 = 0, roi_y0 = 0, roi_w = 12'(H), roi_h = 12'(V);

   logic            wr_en, busy, fstart, fdone, err_size, err_ovf;
   logic [AW-1:0]   wr_addr;
   logic [2*PW-1:0] wr_data;
   logic [15:0]     frame_cnt;

   wr_t exp_q[$];
   int  n_total = 0, n_bad = 0;
   int  done_cnt = 0, fs_cnt = 0;
   int  exp_addr = 0, pix_idx = 0, stall_pix = -1;

   always #5 CLK = ~CLK;

   cam_capture_ctrl #(.PIXEL_WIDTH(PW), .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .iSTART       (start),
      .iABORT       (abort),
      .iCONTINUOUS  (cont),
      .iVSYNC       (vsync),
      .iHSYNC       (hsync),
      .iDE          (de),
      .iDATA_L      (data_l),
      .iDATA_R      (data_r),
      .iWR_READY    (ready),
`ifdef CAM_ROI_CROP_EN
      .iROI_X0      (roi_x0),
      .iROI_Y0      (roi_y0),
      .iROI_W       (roi_w),
      .iROI_H       (roi_h),
`endif
      .oWR_EN       (wr_en),
      .oWR_ADDR     (wr_addr),
      .oWR_DATA     (wr_data),
      .oBUSY        (busy),
      .oFRAME_START (fstart),
      .oFRAME_DONE  (fdone),
      .oERR_SIZE    (err_size),
      .oERR_OVF     (err_ovf),
      .oFRAME_CNT   (frame_cnt)
   );

   // Monitor: compares every presented write against the scoreboard.
   always @(negedge CLK) begin
      if (!RST) begin
         if (fdone)  done_cnt++;
         if (fstart) fs_cnt++;
         if (wr_en) begin
            n_total++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write got addr=%0d data=%h", wr_addr, wr_data);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               if (wr_addr !== e.addr || wr_data !== e.data) begin
                  n_bad++;
                  $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                           wr_addr, wr_data, e.addr, e.data);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic bit in_roi(input int c, input int ln);
      return c >= int'(roi_x0) && c < int'(roi_x0) + int'(roi_w) &&
             ln >= int'(roi_y0) && ln < int'(roi_y0) + int'(roi_h);
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_line(input int ln, input int npix, input bit expect_wr);
      wr_t e;
      hsync = 1'b1;
      tick();
      for (int c = 0; c < npix; c++) begin
         de     = 1'b1;
         data_l = PW'(ln * 16 + c);
         data_r = PW'(255 - ln * 16 - c);
         ready  = !(stall_pix >= 0 && (pix_idx == stall_pix || pix_idx == stall_pix + 1));
         if (expect_wr && ready && in_roi(c, ln) && exp_addr < int'(roi_w) * int'(roi_h)) begin
            e.addr = AW'(exp_addr);
            e.data = {data_r, data_l};
            exp_q.push_back(e);
            exp_addr++;
         end
         pix_idx++;
         tick();
      end
      de    = 1'b0;
      ready = 1'b1;
      tick();
      hsync = 1'b0;
      settle(2);
   endtask

   task automatic frame_open();
      vsync = 1'b0;
      settle(2);
      vsync = 1'b1;
      exp_addr = 0;
      pix_idx  = 0;
      settle(2);
   endtask

   task automatic send_frame(input int n_lines, input int short_ln, input bit expect_wr);
      frame_open();
      for (int ln = 0; ln < n_lines; ln++)
         send_line(ln, (ln == short_ln) ? H - 1 : H, expect_wr);
      vsync = 1'b0;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      settle(3);
      check("rst_busy", 32'(busy), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_frame_cnt", 32'(frame_cnt), 0);
      check("rst_errs", {30'd0, err_size, err_ovf}, 0);
      RST = 1'b0;
      settle(2);

      // Single-shot full frame.
      pulse_start();
      check("armed_busy", 32'(busy), 1);
      send_frame(V, -1, 1);
      settle(3);
      check("t1_done", 32'(done_cnt), 1);
      check("t1_fs", 32'(fs_cnt), 1);
      check("t1_frame_cnt", 32'(frame_cnt), 1);
      check("t1_errs", {30'd0, err_size, err_ovf}, 0);
      check("t1_busy", 32'(busy), 0);
      check("t1_last_addr", 32'(wr_addr), 31);
      check("t1_q_empty", 32'(exp_q.size()), 0);

      // Armed mid-frame: the partial frame must be skipped.
      vsync = 1'b1;
      tick();
      pulse_start();
      check("t2_addr_clr", 32'(wr_addr), 0);
      send_line(0, H, 0);
      vsync = 1'b0;
      tick();
      send_frame(V, -1, 1);
      settle(3);
      check("t2_frame_cnt", 32'(frame_cnt), 2);
      check("t2_fs", 32'(fs_cnt), 2);
      check("t2_errs", {30'd0, err_size, err_ovf}, 0);
      check("t2_q_empty", 32'(exp_q.size()), 0);

      // Continuous: three frames, then abort inside the fourth.
      cont = 1'b1;
      pulse_start();
      for (int f = 0; f < 3; f++) send_frame(V, -1, 1);
      check("t3_busy_rearmed", 32'(busy), 1);
      frame_open();
      send_line(0, H, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      cont  = 1'b0;
      check("t3_abort_idle", 32'(busy), 0);
      vsync = 1'b0;
      settle(4);
      check("t3_frame_cnt", 32'(frame_cnt), 5);
      check("t3_done", 32'(done_cnt), 5);
      check("t3_fs", 32'(fs_cnt), 6);
      check("t3_q_empty", 32'(exp_q.size()), 0);

      // Short line sets the sticky size error.
      pulse_start();
      send_frame(V, 1, 1);
      settle(3);
      check("t4_short_err", 32'(err_size), 1);
      check("t4_frame_cnt", 32'(frame_cnt), 6);
      settle(5);
      check("t4_err_sticky", 32'(err_size), 1);
      pulse_start();
      check("t4_err_clr", 32'(err_size), 0);
      // Five lines: the excess line must not be written.
      send_frame(V + 1, -1, 1);
      settle(3);
      check("t4_long_err", 32'(err_size), 1);
      check("t4_long_ovf", 32'(err_ovf), 0);
      check("t4_long_last", 32'(wr_addr), 31);
      check("t4_q_empty", 32'(exp_q.size()), 0);

      // Two pixels dropped while the frame buffer is not ready.
      stall_pix = 10;
      pulse_start();
      send_frame(V, -1, 1);
      stall_pix = -1;
      settle(3);
      check("t5_ovf", 32'(err_ovf), 1);
      check("t5_size", 32'(err_size), 0);
      check("t5_last_addr", 32'(wr_addr), 29);
      check("t5_frame_cnt", 32'(frame_cnt), 8);
      check("t5_q_empty", 32'(exp_q.size()), 0);

`ifdef CAM_ROI_CROP_EN
      // ROI (2,1,4,2) on the 8x4 frame.
      roi_x0 = 12'd2; roi_y0 = 12'd1; roi_w = 12'd4; roi_h = 12'd2;
      pulse_start();
      send_frame(V, -1, 1);
      settle(3);
      check("roi_last_addr", 32'(wr_addr), 7);
      check("roi_errs", {30'd0, err_size, err_ovf}, 0);
      check("roi_frame_cnt", 32'(frame_cnt), 9);
      check("roi_q_empty", 32'(exp_q.size()), 0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/cam_capture_ctrl.md
# cam_capture_ctrl

Frame capture controller that sits directly after the camera input register stage and sequences acquisition of stereo (left/right) pixel data into the frame buffer write port. Arms on a software start, aligns to the next full frame, generates linear write addresses, and checks received frame geometry. Supports single-shot and continuous capture, with sticky error reporting toward the register block.

## Interface
- PIXEL_WIDTH, 8, bits per pixel per eye
- H_ACTIVE, 640, expected DE pixels per line
- V_ACTIVE, 480, expected lines with DE per frame
- ADDR_WIDTH, 19, frame buffer word address width; must satisfy 2^ADDR_WIDTH >= H_ACTIVE*V_ACTIVE
- CLK  in  1  pixel clock; the block's only clock
- RST  in  1  reset, asynchronous, active-high
- iSTART  in  1  one-cycle arm pulse
- iABORT  in  1  one-cycle abort pulse
- iCONTINUOUS  in  1  1 = re-arm automatically after each frame
- iVSYNC, iHSYNC, iDE  in  1 each  polarity-normalised (active-high) frame/line/data valid
- iDATA_L, iDATA_R  in  PIXEL_WIDTH each  pixel data
- iWR_READY  in  1  frame buffer can accept a word this cycle
- oWR_EN  out  1  write strobe
- oWR_ADDR  out  ADDR_WIDTH  word address
- oWR_DATA  out  2*PIXEL_WIDTH  {iDATA_R, iDATA_L}
- oBUSY  out  1  state != IDLE
- oFRAME_START, oFRAME_DONE  out  1 each  one-cycle pulses
- oERR_SIZE, oERR_OVF  out  1 each  sticky errors
- oFRAME_CNT  out  16  completed-frame count, wraps at 65535 -> 0

## Operation
- States: IDLE, WAIT_LOW (VSYNC must be seen low), WAIT_FS (wait VSYNC rise), CAPTURE.
- IDLE --iSTART--> WAIT_LOW; iSTART clears oERR_SIZE, oERR_OVF, oWR_ADDR. iSTART outside IDLE is ignored.
- WAIT_LOW --!iVSYNC--> WAIT_FS; prevents capture of a partial frame when armed mid-frame.
- WAIT_FS --VSYNC rising edge--> CAPTURE; pulses oFRAME_START; line/pixel counters and address cleared.
- CAPTURE: each cycle with iDE&iHSYNC&iVSYNC is a pixel. If iWR_READY=1 and address < H_ACTIVE*V_ACTIVE: write, address +1. If iWR_READY=0: pixel dropped, oERR_OVF set. If address limit reached: dropped, oERR_SIZE set.
- Pixel counter counts DE per line; on HSYNC falling edge, a line with >=1 pixel increments line counter; pixel count != H_ACTIVE sets oERR_SIZE; pixel counter clears.
- VSYNC falling edge in CAPTURE: line count != V_ACTIVE sets oERR_SIZE; oFRAME_DONE pulses; oFRAME_CNT +1; next state WAIT_FS if iCONTINUOUS else IDLE.
- iABORT in any state: IDLE next cycle, no oFRAME_DONE, oFRAME_CNT unchanged, errors kept. iABORT and iSTART together: abort wins.
- Counters are width-saturating (pixel 16 bit, line 16 bit); no wrap within a frame.

## Timing
- Reset: state IDLE, all outputs 0, oFRAME_CNT 0.
- Edge detect uses one registered copy of iVSYNC/iHSYNC; an edge is detected the cycle the new level is sampled.
- oWR_EN/oWR_ADDR/oWR_DATA registered: latency 1 cycle from the qualifying input cycle; oWR_EN is a single cycle per pixel.
- oFRAME_START: 1 cycle after VSYNC rise sampled. oFRAME_DONE: 1 cycle after VSYNC fall sampled, and after the frame's last write.
- iCONTINUOUS sampled at the VSYNC-fall cycle only.
- Back-to-back frames: a VSYNC rise 1 cycle after the fall is captured in continuous mode.

## Configuration
- CAM_ROI_CROP_EN defined: adds inputs iROI_X0, iROI_Y0, iROI_W, iROI_H (12 bits each, static while oBUSY). Only pixels with X0 <= px < X0+W and Y0 <= ln < Y0+H are written; the address limit becomes W*H; geometry checks still use H_ACTIVE/V_ACTIVE.
- Undefined: ROI ports absent, every active pixel is written.

## Structure
- Package cam_capture_pkg: state enum encoding, counter width constant (16), ROI width constant (12).
- One sub-module: cam_sync_edge_det (registers VSYNC/HSYNC, outputs rise/fall pulses).

## Test plan
- Single-shot, H_ACTIVE=8, V_ACTIVE=4, iWR_READY=1 -> 32 writes, addr 0..31, oFRAME_DONE once, oFRAME_CNT=1, no errors, oBUSY=0.
- iSTART mid-frame (VSYNC high) -> no writes until the following frame; that frame captured fully.
- Continuous, 3 frames, then iABORT during frame 4 -> oFRAME_CNT=3, state IDLE next cycle, no 4th oFRAME_DONE.
- Line of 7 pixels in an 8-pixel frame -> oERR_SIZE=1, stays set until next iSTART; 5-line frame -> oERR_SIZE=1, excess pixels not written.
- iWR_READY low for 2 pixel cycles -> 2 pixels dropped, oERR_OVF=1, address advances only on accepted writes.
- CAM_ROI_CROP_EN, ROI (2,1,4,2) on 8x4 -> 8 writes, addr 0..7, pixel data from columns 2..5, lines 1..2.
